// File: rtl/axis_packet_master.sv
// Packet-framing AXI-Stream master: a show-ahead FIFO feeds a two-state
// framer that emits pkt_len+1 beats per start request with tlast on the final beat.
module axis_packet_master #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int LEN_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    input  logic                     start,
    input  logic [LEN_W-1:0]         pkt_len,
    input  logic                     tready,
    output logic                     tvalid,
    output logic [DATA_W-1:0]        tdata,
    output logic                     tlast,
    output logic                     busy,
    output logic                     pkt_done,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE,
        TX
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       level;
    logic [LEN_W-1:0]  len_q, len_nxt;
    logic [LEN_W-1:0]  beat_cnt, beat_nxt;
    logic              done_nxt;
    logic              wr_en, rd_en, last_beat;

    // Full blocks writes outright; no write-through even when a read pops.
    assign in_ready   = (level != FULL_LVL);
    assign fifo_level = level;
    assign wr_en      = in_valid && in_ready;

    assign busy      = (state == TX);
    assign tvalid    = (state == TX) && (level != '0);
    assign rd_en     = tvalid && tready;
    assign last_beat = (beat_cnt == len_q);
    assign tlast     = tvalid && last_beat;
    assign tdata     = tvalid ? mem[rd_ptr] : '0;

    always_comb begin
        state_nxt = state;
        len_nxt   = len_q;
        beat_nxt  = beat_cnt;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    len_nxt   = pkt_len;
                    beat_nxt  = '0;
                    state_nxt = TX;
                end
            end
            TX: begin
                if (rd_en) begin
                    beat_nxt = beat_cnt + LEN_W'(1);
                    if (last_beat) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            len_q    <= '0;
            beat_cnt <= '0;
            pkt_done <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
        end else begin
            state    <= state_nxt;
            len_q    <= len_nxt;
            beat_cnt <= beat_nxt;
            pkt_done <= done_nxt;
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage carries no reset; tdata is gated by tvalid so stale words never show.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem[wr_ptr] <= in_data;
    end

endmodule

// File: tb/tb_axis_packet_master.sv
// Bench for axis_packet_master: directed vector table, corner-case sequences
// and randomized traffic checked against a queue-based packet model.
module tb_axis_packet_master;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int LEN_W  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = '0;
    logic             in_ready;
    logic             start = 1'b0;
    logic [7:0]       pkt_len = '0;
    logic             tready = 1'b0;
    logic             tvalid;
    logic [7:0]       tdata;
    logic             tlast;
    logic             busy;
    logic             pkt_done;
    logic [2:0]       fifo_level;

    axis_packet_master #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .start(start), .pkt_len(pkt_len), .tready(tready),
        .tvalid(tvalid), .tdata(tdata), .tlast(tlast), .busy(busy),
        .pkt_done(pkt_done), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of buffered words plus remaining beats of the open packet.
    logic [7:0] q[$];
    bit         mdl_valid = 0;
    bit         in_pkt = 0;
    int         beats_left = 0;
    bit         done_exp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Packed output word: {in_ready, tvalid, tdata, tlast, busy, pkt_done, fifo_level}
    function automatic logic [15:0] pack_out();
        return {in_ready, tvalid, tdata, tlast, busy, pkt_done, fifo_level};
    endfunction

    task automatic step(input logic r, input logic iv, input logic [7:0] d,
                        input logic st, input logic [7:0] l, input logic tr,
                        input bit use_exp, input logic [15:0] exp);
        bit exp_tv, wr, rd, new_done;
        @(negedge clk);
        rst = r; in_valid = iv; in_data = d; start = st; pkt_len = l; tready = tr;
        #1;
        exp_tv = in_pkt && (q.size() > 0);
        if (use_exp) chk("vector", 32'(pack_out()), 32'(exp));
        if (mdl_valid) begin
            chk("in_ready",   32'(in_ready),   32'(q.size() != DEPTH));
            chk("tvalid",     32'(tvalid),     32'(exp_tv));
            chk("tdata",      32'(tdata),      exp_tv ? 32'(q[0]) : 32'd0);
            chk("tlast",      32'(tlast),      32'(exp_tv && beats_left == 1));
            chk("busy",       32'(busy),       32'(in_pkt));
            chk("pkt_done",   32'(pkt_done),   32'(done_exp));
            chk("fifo_level", 32'(fifo_level), 32'(q.size()));
        end
        if (r) begin
            q.delete(); in_pkt = 0; beats_left = 0; done_exp = 0; mdl_valid = 1;
        end else if (mdl_valid) begin
            wr = iv && (q.size() != DEPTH);
            rd = exp_tv && tr;
            new_done = 0;
            if (rd) begin
                void'(q.pop_front());
                beats_left--;
                if (beats_left == 0) begin in_pkt = 0; new_done = 1; end
            end else if (!in_pkt && st) begin
                in_pkt = 1; beats_left = int'(l) + 1;
            end
            if (wr) q.push_back(d);
            done_exp = new_done;
        end
        @(posedge clk);
    endtask

    task automatic drive(input logic r, input logic iv, input logic [7:0] d,
                         input logic st, input logic [7:0] l, input logic tr);
        step(r, iv, d, st, l, tr, 1'b0, '0);
    endtask

    typedef struct {
        logic        r, iv, st, tr;
        logic [7:0]  d, l;
        bit          use_exp;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[12];

    // {in_ready, tvalid, tdata, tlast, busy, pkt_done, level}
    function automatic logic [15:0] o(input logic ir, tv, input logic [7:0] td,
                                      input logic tl, bz, pd, input logic [2:0] lv);
        return {ir, tv, td, tl, bz, pd, lv};
    endfunction

    initial begin
        // Four words then a 4-beat packet with tready held high.
        vecs[0]  = '{1, 0, 0, 0, 8'h00, 8'd0, 0, '0};
        vecs[1]  = '{0, 1, 0, 0, 8'hA1, 8'd0, 1, o(1, 0, 8'h00, 0, 0, 0, 3'd0)};
        vecs[2]  = '{0, 1, 0, 0, 8'hA2, 8'd0, 1, o(1, 0, 8'h00, 0, 0, 0, 3'd1)};
        vecs[3]  = '{0, 1, 0, 0, 8'hA3, 8'd0, 1, o(1, 0, 8'h00, 0, 0, 0, 3'd2)};
        vecs[4]  = '{0, 1, 0, 0, 8'hA4, 8'd0, 1, o(1, 0, 8'h00, 0, 0, 0, 3'd3)};
        vecs[5]  = '{0, 0, 1, 1, 8'h00, 8'd3, 1, o(0, 0, 8'h00, 0, 0, 0, 3'd4)};
        vecs[6]  = '{0, 0, 0, 1, 8'h00, 8'd0, 1, o(0, 1, 8'hA1, 0, 1, 0, 3'd4)};
        vecs[7]  = '{0, 0, 0, 1, 8'h00, 8'd0, 1, o(1, 1, 8'hA2, 0, 1, 0, 3'd3)};
        vecs[8]  = '{0, 0, 0, 1, 8'h00, 8'd0, 1, o(1, 1, 8'hA3, 0, 1, 0, 3'd2)};
        vecs[9]  = '{0, 0, 0, 1, 8'h00, 8'd0, 1, o(1, 1, 8'hA4, 1, 1, 0, 3'd1)};
        vecs[10] = '{0, 0, 0, 0, 8'h00, 8'd0, 1, o(1, 0, 8'h00, 0, 0, 1, 3'd0)};
        vecs[11] = '{0, 0, 0, 0, 8'h00, 8'd0, 1, o(1, 0, 8'h00, 0, 0, 0, 3'd0)};

        for (int i = 0; i < 12; i++)
            step(vecs[i].r, vecs[i].iv, vecs[i].d, vecs[i].st, vecs[i].l,
                 vecs[i].tr, vecs[i].use_exp, vecs[i].exp);

        // Fill, offer a fifth word while full, then read and write together.
        for (int i = 0; i < 4; i++) drive(0, 1, 8'hB0 + 8'(i), 0, 0, 0);
        drive(0, 1, 8'hBE, 0, 0, 0);
        drive(0, 1, 8'hBE, 0, 0, 0);
        drive(0, 1, 8'hBF, 1, 8'd3, 0);
        drive(0, 1, 8'hBF, 0, 0, 1);
        drive(0, 1, 8'hC0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0, 1);

        // Packet of 3 with only one word available, then the rest trickles in.
        drive(0, 1, 8'hD1, 1, 8'd2, 1);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1);
        drive(0, 1, 8'hD2, 0, 0, 1);
        drive(0, 1, 8'hD3, 0, 0, 1);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 1);

        // Backpressure for three cycles on beat 2 of 4.
        for (int i = 0; i < 4; i++) drive(0, 1, 8'hE0 + 8'(i), 0, 0, 0);
        drive(0, 0, 0, 1, 8'd3, 1);
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 1);

        // Single-beat packet; a start during TX must not open a second one.
        drive(0, 1, 8'hF1, 0, 0, 0);
        drive(0, 1, 8'hF2, 1, 8'd0, 0);
        drive(0, 0, 0, 1, 8'd0, 0);
        drive(0, 0, 0, 1, 8'd0, 1);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 8'd0, 1);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 1);

        // Reset after the first beat of a 4-beat packet.
        for (int i = 0; i < 4; i++) drive(0, 1, 8'h90 + 8'(i), 0, 0, 0);
        drive(0, 0, 0, 1, 8'd3, 1);
        drive(0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 1'b1, o(1, 0, 8'h00, 0, 0, 0, 3'd0));
        drive(0, 0, 0, 0, 0, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 2) != 0),
                  8'($urandom),
                  ($urandom_range(0, 5) == 0),
                  8'($urandom_range(0, 5)),
                  ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
